// File: rtl/tri_raster_scan.sv
// Raster-scan sequencer for the point-in-triangle tester.
// It walks the clipped vertex bounding box, issues each point to the tester and streams out the inside pixels.
module tri_raster_scan #(
   parameter int CW       = 11,
   parameter int XMAX     = 799,
   parameter int YMAX     = 599,
   parameter int TEST_LAT = 1
) (
   input  logic          CLOCK_50,
   input  logic          RESET_N,
   input  logic          start,
   input  logic [CW-1:0] p1x,
   input  logic [CW-1:0] p1y,
   input  logic [CW-1:0] p2x,
   input  logic [CW-1:0] p2y,
   input  logic [CW-1:0] p3x,
   input  logic [CW-1:0] p3y,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] test_px,
   output logic [CW-1:0] test_py,
   input  logic          test_in,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic [19:0]   pix_count
);

   // state | meaning
   // IDLE  | waiting for start; vertices latched when it arrives
   // SETUP | bounding box computed and clipped; empty box skips to DONE
   // ISSUE | candidate point presented to the tester
   // WAIT  | tester latency; inside flag sampled in the last cycle
   // EMIT  | inside pixel held on the stream until accepted
   // DONE  | one-cycle completion pulse

   typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, EMIT, DONE} state_t;

   localparam int            LW       = (TEST_LAT < 2) ? 1 : $clog2(TEST_LAT + 1);
   localparam logic [LW-1:0] LAT_INIT = LW'(TEST_LAT);
   localparam logic [LW-1:0] LAT_ONE  = LW'(1);
   localparam logic [CW-1:0] XMAX_C   = CW'(XMAX);
   localparam logic [CW-1:0] YMAX_C   = CW'(YMAX);

   state_t        state, state_nxt;
   logic [CW-1:0] vx [3];
   logic [CW-1:0] vy [3];
   logic [CW-1:0] xmin, xmax, ymin, ymax;
   logic [CW-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax, bb_xraw, bb_yraw;
   logic [CW-1:0] cx, cy, cx_nxt, cy_nxt;
   logic [LW-1:0] lat_cnt, lat_nxt;
   logic          latch_v, advance, emit_load, count_inc;

   function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
      logic [CW-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
      logic [CW-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   always_comb begin
      bb_xmin = min3(vx[0], vx[1], vx[2]);
      bb_ymin = min3(vy[0], vy[1], vy[2]);
      bb_xraw = max3(vx[0], vx[1], vx[2]);
      bb_yraw = max3(vy[0], vy[1], vy[2]);
      bb_xmax = (bb_xraw > XMAX_C) ? XMAX_C : bb_xraw;
      bb_ymax = (bb_yraw > YMAX_C) ? YMAX_C : bb_yraw;
   end

   always_comb begin
      state_nxt = state;
      cx_nxt    = cx;
      cy_nxt    = cy;
      lat_nxt   = lat_cnt;
      latch_v   = 1'b0;
      advance   = 1'b0;
      emit_load = 1'b0;
      count_inc = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               latch_v   = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if ((bb_xmin > bb_xmax) || (bb_ymin > bb_ymax)) begin
               state_nxt = DONE;
            end else begin
               cx_nxt    = bb_xmin;
               cy_nxt    = bb_ymin;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            lat_nxt   = LAT_INIT;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (lat_cnt == LAT_ONE) begin
               if (test_in) begin
                  emit_load = 1'b1;
                  state_nxt = EMIT;
               end else begin
                  advance = 1'b1;
               end
            end else begin
               lat_nxt = lat_cnt - LAT_ONE;
            end
         end
         EMIT: begin
            if (pix_ready) begin
               count_inc = 1'b1;
               advance   = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Raster step; cx/cy only ever move up to the clipped box edge, so no wrap.
      if (advance) begin
         if (cx < xmax) begin
            cx_nxt    = cx + 1'b1;
            state_nxt = ISSUE;
         end else if (cy < ymax) begin
            cx_nxt    = xmin;
            cy_nxt    = cy + 1'b1;
            state_nxt = ISSUE;
         end else begin
            state_nxt = DONE;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         for (int i = 0; i < 3; i++) begin
            vx[i] <= '0;
            vy[i] <= '0;
         end
         xmin      <= '0;
         xmax      <= '0;
         ymin      <= '0;
         ymax      <= '0;
         cx        <= '0;
         cy        <= '0;
         lat_cnt   <= '0;
         test_px   <= '0;
         test_py   <= '0;
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_count <= '0;
      end else begin
         state   <= state_nxt;
         cx      <= cx_nxt;
         cy      <= cy_nxt;
         lat_cnt <= lat_nxt;
         if (latch_v) begin
            vx[0]     <= p1x;
            vx[1]     <= p2x;
            vx[2]     <= p3x;
            vy[0]     <= p1y;
            vy[1]     <= p2y;
            vy[2]     <= p3y;
            pix_count <= '0;
         end
         if (state == SETUP) begin
            xmin <= bb_xmin;
            xmax <= bb_xmax;
            ymin <= bb_ymin;
            ymax <= bb_ymax;
         end
         // Tester inputs change only on entry to ISSUE and stay put through WAIT/EMIT.
         if (state_nxt == ISSUE) begin
            test_px <= cx_nxt;
            test_py <= cy_nxt;
         end
         if (emit_load) begin
            pix_valid <= 1'b1;
            pix_x     <= cx;
            pix_y     <= cy;
         end else if (count_inc) begin
            pix_valid <= 1'b0;
            if (pix_count != '1) pix_count <= pix_count + 1'b1;
         end
      end
   end

   assign busy = (state == SETUP) || (state == ISSUE) || (state == WAIT) || (state == EMIT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_tri_raster_scan.sv
// Directed bench for tri_raster_scan with a behavioural one-cycle tester model.
module tb_tri_raster_scan;
   localparam int CW = 11;

   logic          CLOCK_50 = 1'b0;
   logic          RESET_N  = 1'b0;
   logic          start    = 1'b0;
   logic [CW-1:0] p1x = '0, p1y = '0, p2x = '0, p2y = '0, p3x = '0, p3y = '0;
   logic          busy, done, pix_valid;
   logic [CW-1:0] test_px, test_py, pix_x, pix_y;
   logic          test_in   = 1'b0;
   logic          pix_ready = 1'b0;
   logic [19:0]   pix_count;

   tri_raster_scan #(.CW(CW), .XMAX(799), .YMAX(599), .TEST_LAT(1)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .start    (start),
      .p1x      (p1x),
      .p1y      (p1y),
      .p2x      (p2x),
      .p2y      (p2y),
      .p3x      (p3x),
      .p3y      (p3y),
      .busy     (busy),
      .done     (done),
      .test_px  (test_px),
      .test_py  (test_py),
      .test_in  (test_in),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .pix_x    (pix_x),
      .pix_y    (pix_y),
      .pix_count(pix_count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int n_chk  = 0;
   int n_fail = 0;
   int tv [6];
   int exp_x[$];
   int exp_y[$];
   int n_exp, done_cnt, busy_cyc, max_px, emit_cnt;

   task automatic check_val(input string tag, input longint obs, input longint expv);
      n_chk++;
      if (obs != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic bit in_tri(input int px, input int py);
      int e1, e2, e3;
      e1 = (tv[2] - tv[0]) * (py - tv[1]) - (tv[3] - tv[1]) * (px - tv[0]);
      e2 = (tv[4] - tv[2]) * (py - tv[3]) - (tv[5] - tv[3]) * (px - tv[2]);
      e3 = (tv[0] - tv[4]) * (py - tv[5]) - (tv[1] - tv[5]) * (px - tv[4]);
      return ((e1 >= 0) && (e2 >= 0) && (e3 >= 0)) || ((e1 <= 0) && (e2 <= 0) && (e3 <= 0));
   endfunction

   // Tester: flag for the point driven one clock earlier.
   always @(posedge CLOCK_50) test_in <= in_tri(int'(test_px), int'(test_py));

   always @(negedge CLOCK_50) begin
      if (RESET_N) begin
         if (done) done_cnt++;
         if (busy) begin
            busy_cyc++;
            if (int'(test_px) > max_px) max_px = int'(test_px);
         end
         if (pix_valid && pix_ready) begin
            emit_cnt++;
            if (exp_x.size() == 0) begin
               check_val("emit_extra", emit_cnt, n_exp);
            end else begin
               check_val("pix_x", pix_x, exp_x.pop_front());
               check_val("pix_y", pix_y, exp_y.pop_front());
            end
         end
      end
   end

   task automatic set_tri(input int ax, ay, bx, by, cx, cy);
      tv[0] = ax; tv[1] = ay; tv[2] = bx; tv[3] = by; tv[4] = cx; tv[5] = cy;
      p1x = 11'(ax); p1y = 11'(ay);
      p2x = 11'(bx); p2y = 11'(by);
      p3x = 11'(cx); p3y = 11'(cy);
   endtask

   task automatic prepare();
      int x0, x1, y0, y1;
      done_cnt = 0; busy_cyc = 0; max_px = 0; emit_cnt = 0;
      exp_x.delete();
      exp_y.delete();
      x0 = tv[0]; x1 = tv[0]; y0 = tv[1]; y1 = tv[1];
      for (int i = 1; i < 3; i++) begin
         if (tv[2*i] < x0) x0 = tv[2*i];
         if (tv[2*i] > x1) x1 = tv[2*i];
         if (tv[2*i+1] < y0) y0 = tv[2*i+1];
         if (tv[2*i+1] > y1) y1 = tv[2*i+1];
      end
      if (x1 > 799) x1 = 799;
      if (y1 > 599) y1 = 599;
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            if (in_tri(x, y)) begin
               exp_x.push_back(x);
               exp_y.push_back(y);
            end
      n_exp = exp_x.size();
   endtask

   task automatic pulse_start();
      @(negedge CLOCK_50) start = 1'b1;
      @(negedge CLOCK_50) start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, input string tag);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge CLOCK_50);
         if (done) break;
      end
      check_val({tag, "_done"}, done, 1);
      repeat (4) @(negedge CLOCK_50);
      check_val({tag, "_done_once"}, done_cnt, 1);
      check_val({tag, "_busy_after"}, busy, 0);
      check_val({tag, "_exp_left"}, exp_x.size(), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      check_val({tag, "_pix_valid"}, pix_valid, 0);
      check_val({tag, "_test_px"}, test_px, 0);
      check_val({tag, "_test_py"}, test_py, 0);
      check_val({tag, "_pix_x"}, pix_x, 0);
      check_val({tag, "_pix_y"}, pix_y, 0);
      check_val({tag, "_pix_count"}, pix_count, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #5 check_reset_vals("reset");
      repeat (2) @(negedge CLOCK_50);
      RESET_N = 1'b1;

      // Right triangle, always ready: 25 points, 15 inside, 1 + 25*2 + 15 busy cycles.
      set_tri(0, 0, 4, 0, 0, 4);
      pix_ready = 1'b1;
      prepare();
      pulse_start();
      wait_done(200, "t1");
      check_val("t1_pix_count", pix_count, 15);
      check_val("t1_emits", emit_cnt, 15);
      check_val("t1_busy_cyc", busy_cyc, 66);

      // Same triangle with the first pixel stalled for 10 cycles.
      pix_ready = 1'b0;
      prepare();
      pulse_start();
      for (int i = 0; i < 50; i++) begin
         if (pix_valid) break;
         @(negedge CLOCK_50);
      end
      check_val("t2_valid_seen", pix_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLOCK_50);
         check_val("t2_hold_valid", pix_valid, 1);
         check_val("t2_hold_x", pix_x, 0);
         check_val("t2_hold_y", pix_y, 0);
         check_val("t2_hold_test_px", test_px, 0);
         check_val("t2_hold_count", pix_count, 0);
      end
      pix_ready = 1'b1;
      wait_done(200, "t2");
      check_val("t2_pix_count", pix_count, 15);
      check_val("t2_emits", emit_cnt, 15);

      // Coincident vertices: single point, emitted as the tester reports it.
      set_tri(5, 5, 5, 5, 5, 5);
      prepare();
      pulse_start();
      wait_done(50, "t3");
      check_val("t3_pix_count", pix_count, 1);
      check_val("t3_busy_cyc", busy_cyc, 4);
      check_val("t3_test_px", test_px, 5);

      // Entirely right of the screen: empty box, done in cycle 2.
      set_tri(800, 0, 810, 5, 820, 10);
      prepare();
      @(negedge CLOCK_50) start = 1'b1;
      @(negedge CLOCK_50) start = 1'b0;
      check_val("t4_c1_busy", busy, 1);
      check_val("t4_c1_done", done, 0);
      @(negedge CLOCK_50);
      check_val("t4_c2_done", done, 1);
      check_val("t4_c2_busy", busy, 0);
      @(negedge CLOCK_50);
      check_val("t4_c3_done", done, 0);
      check_val("t4_pix_count", pix_count, 0);
      check_val("t4_busy_cyc", busy_cyc, 1);
      check_val("t4_test_px_kept", test_px, 5);
      check_val("t4_emits", emit_cnt, 0);

      // Clipped at XMAX: 10x11 box, 101 inside; mid-scan start ignored.
      set_tri(790, 0, 900, 0, 790, 10);
      prepare();
      pulse_start();
      repeat (20) @(negedge CLOCK_50);
      pulse_start();
      wait_done(1000, "t5");
      check_val("t5_max_px", max_px, 799);
      check_val("t5_pix_count", pix_count, 101);
      check_val("t5_emits", emit_cnt, 101);
      check_val("t5_busy_cyc", busy_cyc, 322);

      // Reset mid-scan, then a clean rerun.
      set_tri(0, 0, 4, 0, 0, 4);
      prepare();
      pulse_start();
      repeat (25) @(negedge CLOCK_50);
      check_val("t6_busy_before", busy, 1);
      #3 RESET_N = 1'b0;
      #1 check_reset_vals("t6_async");
      done_cnt = 0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50) RESET_N = 1'b1;
      prepare();
      pulse_start();
      wait_done(200, "t6");
      check_val("t6_pix_count", pix_count, 15);
      check_val("t6_emits", emit_cnt, 15);
      check_val("t6_busy_cyc", busy_cyc, 66);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
